// File: rtl/tm_pkg.sv
// tm_pkg: shared defaults and FSM state encoding for the TM argmax sequencer.
// Optional build macro: TM_CLAMP_EN enables per-class saturation at capture.
package tm_pkg;

   localparam int TM_NUM_CLASSES = 10;
   localparam int TM_INT_SIZE    = 32;
   localparam int TM_IDX_W       = 4;
   localparam logic signed [31:0] TM_THRESHOLD = 32'sd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } tm_state_e;

endpackage

// File: rtl/tm_sum_clamp.sv
// tm_sum_clamp: combinational signed saturator, limits a sum to [-THRESHOLD, +THRESHOLD].
// Instantiated once per class by tm_argmax_sequencer when TM_CLAMP_EN is defined.
module tm_sum_clamp #(
   parameter int INT_SIZE = 32,
   parameter logic signed [INT_SIZE-1:0] THRESHOLD = INT_SIZE'(15)
) (
   input  logic signed [INT_SIZE-1:0] i_sum,
   output logic signed [INT_SIZE-1:0] o_sum
);

   localparam logic signed [INT_SIZE-1:0] NEG_THRESHOLD = -THRESHOLD;

   // Saturate above and below; values inside the band pass through untouched.
   always_comb begin
      o_sum = i_sum;
      if (i_sum > THRESHOLD) begin
         o_sum = THRESHOLD;
      end else if (i_sum < NEG_THRESHOLD) begin
         o_sum = NEG_THRESHOLD;
      end
   end

endmodule

// File: rtl/tm_argmax_sequencer.sv
// tm_argmax_sequencer: captures the classifier's signed class sums on the rising
// edge of full_done, scans them one class per cycle for the argmax, and offers the
// winning class and sum on a valid/ready handshake.
// Optional build macro: TM_CLAMP_EN saturates each sum to +/-THRESHOLD at capture.
module tm_argmax_sequencer
   import tm_pkg::*;
#(
   parameter int NUM_CLASSES = TM_NUM_CLASSES,
   parameter int INT_SIZE    = TM_INT_SIZE,
   parameter int IDX_W       = TM_IDX_W,
   parameter logic signed [INT_SIZE-1:0] THRESHOLD = TM_THRESHOLD
) (
   input  logic                            clk,
   input  logic                            rst_flag,
   input  logic                            full_done,
   input  logic [NUM_CLASSES*INT_SIZE-1:0] class_sums,
   input  logic                            pred_ready,
   output logic                            pred_valid,
   output logic [IDX_W-1:0]                pred_class,
   output logic [INT_SIZE-1:0]             pred_sum,
   output logic                            busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   // Reject configurations the index width or class count cannot support.
   generate
      if ((NUM_CLASSES < 2) || (NUM_CLASSES > 16) || ((1 << IDX_W) < NUM_CLASSES) ||
          (THRESHOLD < 0)) begin : g_bad_param
         $error("tm_argmax_sequencer: illegal parameter combination");
      end
   endgenerate

   tm_state_e                  r_state;
   logic                       r_done_q;
   logic signed [INT_SIZE-1:0] r_sum [NUM_CLASSES];
   logic signed [INT_SIZE-1:0] r_best_sum;
   logic [IDX_W-1:0]           r_best_idx;
   logic [IDX_W-1:0]           r_scan_idx;
   logic                       r_pred_valid;
   logic [IDX_W-1:0]           r_pred_class;
   logic signed [INT_SIZE-1:0] r_pred_sum;
   logic                       r_busy;

   logic signed [INT_SIZE-1:0] w_cap [NUM_CLASSES];
   logic                       w_start;
   logic                       w_capture;
   logic signed [INT_SIZE-1:0] w_cur;
   logic                       w_better;
   logic signed [INT_SIZE-1:0] w_win_sum;
   logic [IDX_W-1:0]           w_win_idx;

   // Per-class slice of the flat input bus, optionally saturated before storage.
   generate
      for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_class
         logic signed [INT_SIZE-1:0] w_raw;
         assign w_raw = class_sums[gi*INT_SIZE +: INT_SIZE];
`ifdef TM_CLAMP_EN
         tm_sum_clamp #(
            .INT_SIZE  (INT_SIZE),
            .THRESHOLD (THRESHOLD)
         ) u_clamp (
            .i_sum (w_raw),
            .o_sum (w_cap[gi])
         );
`else
         assign w_cap[gi] = w_raw;
`endif
      end
   endgenerate

   // A start is a fresh rising edge of full_done; only IDLE acts on it, so an
   // edge arriving while busy or holding a result is simply lost.
   assign w_start   = full_done & ~r_done_q;
   assign w_capture = (r_state == IDLE) & w_start;

   // Strict compare keeps the earlier (lower) index on ties.
   assign w_cur     = r_sum[r_scan_idx];
   assign w_better  = (w_cur > r_best_sum);
   assign w_win_sum = w_better ? w_cur : r_best_sum;
   assign w_win_idx = w_better ? r_scan_idx : r_best_idx;

   // Snapshot of all class sums, taken on the capture cycle.
   always_ff @(posedge clk) begin
      if (rst_flag) begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            r_sum[i] <= '0;
         end
      end else if (w_capture) begin
         for (int i = 0; i < NUM_CLASSES; i++) begin
            r_sum[i] <= w_cap[i];
         end
      end
   end

   // Control FSM: capture, linear scan, then hold the result until accepted.
   always_ff @(posedge clk) begin
      if (rst_flag) begin
         r_state      <= IDLE;
         r_done_q     <= 1'b0;
         r_best_sum   <= '0;
         r_best_idx   <= '0;
         r_scan_idx   <= '0;
         r_pred_valid <= 1'b0;
         r_pred_class <= '0;
         r_pred_sum   <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_done_q <= full_done;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  // Class 0 seeds the running best straight from the bus.
                  r_best_sum <= w_cap[0];
                  r_best_idx <= '0;
                  r_scan_idx <= IDX_W'(1);
                  r_busy     <= 1'b1;
                  r_state    <= SCAN;
               end
            end
            SCAN: begin
               r_best_sum <= w_win_sum;
               r_best_idx <= w_win_idx;
               r_scan_idx <= r_scan_idx + IDX_W'(1);
               if (r_scan_idx == LAST_IDX) begin
                  r_busy       <= 1'b0;
                  r_pred_valid <= 1'b1;
                  r_pred_class <= w_win_idx;
                  r_pred_sum   <= w_win_sum;
                  r_state      <= DONE;
               end
            end
            DONE: begin
               if (pred_ready) begin
                  r_pred_valid <= 1'b0;
                  r_state      <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign pred_valid = r_pred_valid;
   assign pred_class = r_pred_class;
   assign pred_sum   = r_pred_sum;
   assign busy       = r_busy;

endmodule

// File: tb/tb_tm_argmax_sequencer.sv
// tb_tm_argmax_sequencer: scoreboard bench for the argmax sequencer (default
// parameters). Expected class/sum are computed from the stimulus when full_done is
// raised and compared when the result is handed over. Honours TM_CLAMP_EN.
module tb_tm_argmax_sequencer;

   localparam int NC = 10;
   localparam int W  = 32;

   typedef struct {
      logic [3:0]         cls;
      logic signed [31:0] sum;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_flag;
   logic            full_done;
   logic [NC*W-1:0] class_sums;
   logic            pred_ready;
   logic            pred_valid;
   logic [3:0]      pred_class;
   logic [W-1:0]    pred_sum;
   logic            busy;

   int total = 0;
   int bad   = 0;

   logic signed [31:0] tb_sums [NC];
   exp_t               sb [$];

   always #5 clk = ~clk;

   tm_argmax_sequencer dut (
      .clk        (clk),
      .rst_flag   (rst_flag),
      .full_done  (full_done),
      .class_sums (class_sums),
      .pred_ready (pred_ready),
      .pred_valid (pred_valid),
      .pred_class (pred_class),
      .pred_sum   (pred_sum),
      .busy       (busy)
   );

   function automatic logic signed [31:0] clampv(input logic signed [31:0] v);
`ifdef TM_CLAMP_EN
      if (v > 32'sd15) return 32'sd15;
      if (v < -32'sd15) return -32'sd15;
`endif
      return v;
   endfunction

   // Reference argmax: first strictly greater value wins.
   function automatic exp_t model();
      exp_t e;
      e.cls = 4'd0;
      e.sum = clampv(tb_sums[0]);
      for (int i = 1; i < NC; i++) begin
         if (clampv(tb_sums[i]) > e.sum) begin
            e.cls = 4'(i);
            e.sum = clampv(tb_sums[i]);
         end
      end
      return e;
   endfunction

   task automatic fill(input logic signed [31:0] v);
      for (int i = 0; i < NC; i++) tb_sums[i] = v;
   endtask

   // Drive the bus, raise full_done and record the expected result.
   task automatic arm();
      for (int i = 0; i < NC; i++) class_sums[i*W +: W] = tb_sums[i];
      full_done = 1'b1;
      sb.push_back(model());
   endtask

   task automatic idle_cycle();
      full_done = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Counts edges from the arming negedge until pred_valid is seen; -1 on timeout.
   task automatic wait_valid(output int n, output bit both);
      bit seen;
      n = -1;
      both = 1'b0;
      seen = 1'b0;
      for (int c = 1; c <= 40 && !seen; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (busy && pred_valid) both = 1'b1;
         if (pred_valid) begin
            n = c;
            seen = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst_flag = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (pred_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", pred_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (pred_class !== 4'd0) begin bad++; $display("FAIL reset_class got=%0d want=0", pred_class); end
      total++; if (pred_sum !== 32'd0) begin bad++; $display("FAIL reset_sum got=%0d want=0", $signed(pred_sum)); end
      $display("txn reset: valid=%b busy=%b class=%0d sum=%0d", pred_valid, busy, pred_class, $signed(pred_sum));
      rst_flag = 1'b0;
      @(negedge clk);
   endtask

   // One scenario: load tb_sums, capture, check latency, then transfer and check.
   task automatic run_one(input string name, input bit ready_early);
      int   n;
      bit   both;
      exp_t e;
      idle_cycle();
      pred_ready = ready_early;
      arm();
      wait_valid(n, both);
      // capture edge plus NUM_CLASSES-1 scan edges
      total++; if (n !== NC) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, n, NC); end
      total++; if (both !== 1'b0) begin bad++; $display("FAIL %s_busy_valid_overlap got=%b want=0", name, both); end
      pred_ready = 1'b1;
      total++;
      if (sb.size() == 0) begin
         bad++; $display("FAIL %s_scoreboard got=empty want=entry", name);
      end else begin
         e = sb.pop_front();
         if (pred_class !== e.cls || pred_sum !== e.sum) begin
            bad++;
            $display("FAIL %s_result got=%0d/%0d want=%0d/%0d", name, pred_class, $signed(pred_sum), e.cls, e.sum);
         end
         $display("txn %s: class=%0d sum=%0d exp=%0d/%0d lat=%0d", name, pred_class, $signed(pred_sum), e.cls, e.sum, n);
      end
      @(posedge clk);
      @(negedge clk);
      pred_ready = 1'b0;
      total++; if (pred_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_after_xfer got=v%b/b%b want=v0/b0", name, pred_valid, busy); end
   endtask

   task automatic test_basic();
      tb_sums = '{32'sd3, -32'sd7, 32'sd12, 32'sd0, 32'sd5, -32'sd1, 32'sd4, 32'sd9, 32'sd2, 32'sd11};
      run_one("basic", 1'b0);
   endtask

   task automatic test_tie_negative();
      fill(-32'sd5);
      tb_sums[4] = -32'sd2;
      tb_sums[7] = -32'sd2;
      run_one("tie_neg", 1'b1);
   endtask

   task automatic test_clamp();
      fill(32'sd0);
      tb_sums[1] = 32'sd40;
      tb_sums[6] = 32'sd20;
      run_one("clamp", 1'b0);
   endtask

   task automatic test_extremes();
      fill(32'sd0);
      tb_sums[0] = 32'sh8000_0000;
      tb_sums[9] = 32'sh7FFF_FFFF;
      run_one("extremes", 1'b0);
   endtask

   task automatic test_backpressure();
      int   n;
      int   extra;
      bit   both;
      exp_t e;
      idle_cycle();
      fill(32'sd1);
      tb_sums[5] = 32'sd8;
      arm();
      wait_valid(n, both);
      total++; if (n !== NC) begin bad++; $display("FAIL bp_latency got=%0d want=%0d", n, NC); end
      e = sb[0];
      for (int c = 0; c < 20; c++) begin
         if (c == 5) full_done = 1'b0;
         if (c == 8) full_done = 1'b1;
         @(posedge clk);
         @(negedge clk);
         total++;
         if (pred_valid !== 1'b1 || pred_class !== e.cls || pred_sum !== e.sum || busy !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold_%0d got=v%b %0d/%0d want=v1 %0d/%0d", c, pred_valid, pred_class, $signed(pred_sum), e.cls, e.sum);
         end
      end
      pred_ready = 1'b1;
      e = sb.pop_front();
      total++; if (pred_class !== e.cls || pred_sum !== e.sum) begin bad++; $display("FAIL bp_result got=%0d/%0d want=%0d/%0d", pred_class, $signed(pred_sum), e.cls, e.sum); end
      $display("txn backpressure: class=%0d sum=%0d exp=%0d/%0d", pred_class, $signed(pred_sum), e.cls, e.sum);
      @(posedge clk);
      @(negedge clk);
      pred_ready = 1'b0;
      extra = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (pred_valid || busy) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL bp_no_second got=%0d want=0", extra); end
      total++; if (sb.size() !== 0) begin bad++; $display("FAIL bp_sb_empty got=%0d want=0", sb.size()); end
   endtask

   task automatic test_reset_mid_scan();
      int   n;
      bit   both;
      exp_t e;
      idle_cycle();
      fill(32'sd2);
      tb_sums[8] = 32'sd30;
      arm();
      repeat (5) @(posedge clk);   // capture edge + 4 scan edges
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_scan_busy got=%b want=1", busy); end
      rst_flag = 1'b1;
      void'(sb.pop_back());
      @(posedge clk);
      @(negedge clk);
      total++; if (pred_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rst_scan_abort got=v%b/b%b want=v0/b0", pred_valid, busy); end
      $display("txn reset_mid_scan: valid=%b busy=%b", pred_valid, busy);
      rst_flag = 1'b0;
      fill(-32'sd3);
      tb_sums[3] = 32'sd6;
      arm();                       // full_done stays high across reset
      wait_valid(n, both);
      total++; if (n !== NC) begin bad++; $display("FAIL rst_recap_latency got=%0d want=%0d", n, NC); end
      pred_ready = 1'b1;
      e = sb.pop_front();
      total++; if (pred_class !== e.cls || pred_sum !== e.sum) begin bad++; $display("FAIL rst_recap_result got=%0d/%0d want=%0d/%0d", pred_class, $signed(pred_sum), e.cls, e.sum); end
      $display("txn recapture: class=%0d sum=%0d exp=%0d/%0d", pred_class, $signed(pred_sum), e.cls, e.sum);
      @(posedge clk);
      @(negedge clk);
      pred_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int   n;
      bit   both;
      exp_t e;
      idle_cycle();
      fill(32'sd0);
      tb_sums[2] = 32'sd7;
      arm();
      wait_valid(n, both);
      pred_ready = 1'b1;
      full_done  = 1'b0;           // rearm on the transfer edge
      e = sb.pop_front();
      total++; if (pred_class !== e.cls || pred_sum !== e.sum) begin bad++; $display("FAIL b2b_first got=%0d/%0d want=%0d/%0d", pred_class, $signed(pred_sum), e.cls, e.sum); end
      $display("txn b2b_first: class=%0d sum=%0d exp=%0d/%0d", pred_class, $signed(pred_sum), e.cls, e.sum);
      @(posedge clk);
      @(negedge clk);
      pred_ready = 1'b0;
      fill(32'sd1);
      tb_sums[6] = 32'sd9;
      arm();                       // start sampled on the cycle right after transfer
      wait_valid(n, both);
      total++; if (n !== NC) begin bad++; $display("FAIL b2b_latency got=%0d want=%0d", n, NC); end
      pred_ready = 1'b1;
      e = sb.pop_front();
      total++; if (pred_class !== e.cls || pred_sum !== e.sum) begin bad++; $display("FAIL b2b_second got=%0d/%0d want=%0d/%0d", pred_class, $signed(pred_sum), e.cls, e.sum); end
      $display("txn b2b_second: class=%0d sum=%0d exp=%0d/%0d lat=%0d", pred_class, $signed(pred_sum), e.cls, e.sum, n);
      @(posedge clk);
      @(negedge clk);
      pred_ready = 1'b0;
   endtask

   initial begin
      rst_flag   = 1'b1;
      full_done  = 1'b0;
      pred_ready = 1'b0;
      class_sums = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_tie_negative();
      test_backpressure();
      test_reset_mid_scan();
      test_clamp();
      test_extremes();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tm_argmax_sequencer.md
Name: tm_argmax_sequencer

Overview:
- Downstream stage of the 10-class TM classifier.
- Captures the signed class sums when the classifier's `full_done` rises.
- Scans the captured sums one class per cycle and finds the winning class (argmax).
- Presents the predicted class and its sum on a valid/ready handshake to the result sink (readout, UART, host register).

Parameters:
- NUM_CLASSES, 10: number of class sums; legal range 2..16.
- INT_SIZE, 32: width of each signed class sum.
- IDX_W, 4: width of the class index; must satisfy 2^IDX_W >= NUM_CLASSES.
- THRESHOLD, 32'sd15: clamp bound T. Used only when TM_CLAMP_EN is defined.

Ports:
- clk, input, 1: single clock.
- rst_flag, input, 1: reset. Synchronous, active-high.
- full_done, input, 1: classifier-complete level. Stays high once set.
- class_sums, input, NUM_CLASSES*INT_SIZE: flat bus; class i occupies bits [i*INT_SIZE +: INT_SIZE]; signed two's complement.
- pred_ready, input, 1: sink accepts the result.
- pred_valid, output, 1: result available.
- pred_class, output, IDX_W: winning class index, 0-based.
- pred_sum, output, INT_SIZE: winning sum, signed.
- busy, output, 1: high in CAPTURE or SCAN.

Behaviour:
- Reset (rst_flag high at a clk edge):
  - state=IDLE.
  - pred_valid=0, pred_class=0, pred_sum=0, busy=0.
  - done_q (the full_done delay register) = 0.
  - Captured sums cleared.
  - Reset mid-scan or mid-DONE aborts immediately; no result is emitted.
- Start event:
  - start = full_done & ~done_q, evaluated in IDLE.
  - done_q updates every cycle in every state.
  - A rising edge of full_done seen outside IDLE is ignored; it is not queued.
- States:
  - IDLE: on start, latch all NUM_CLASSES sums into sum_reg[], set best_sum=class_sums[0], best_idx=0, scan_idx=1, go to SCAN.
  - SCAN: each cycle compare sum_reg[scan_idx] > best_sum (signed, strict).
    - If true, update best_sum and best_idx.
    - scan_idx increments by 1.
    - When scan_idx==NUM_CLASSES-1 is processed, go to DONE, load pred_class/pred_sum, set pred_valid=1.
  - DONE: hold pred_valid, pred_class and pred_sum stable. When pred_ready=1 is sampled, go to IDLE and drop pred_valid.
- Ties: strict > means the lowest index wins.
- Latency:
  - Start sampled at edge k gives pred_valid=1 after edge k+NUM_CLASSES-1.
  - With defaults: 9 cycles after capture.
- Handshake:
  - pred_ready high before pred_valid has no effect.
  - Transfer completes on the cycle where valid & ready are both high.
  - The next start may be taken from IDLE the following cycle.
- No arithmetic overflow: comparison only. pred_sum is the raw captured sum (clamped if TM_CLAMP_EN).
- busy = (state==SCAN) or capture cycle. pred_valid and busy are never both high.

Optional Feature:
- Macro: TM_CLAMP_EN.
- Defined:
  - Each sum is saturated to [-THRESHOLD, +THRESHOLD] at capture, before storage.
  - Comparisons and pred_sum use the clamped values.
  - Ties created by clamping resolve to the lowest index.
- Undefined: sums are stored and compared unmodified. No clamp logic is generated.

Decomposition:
- Package tm_pkg:
  - NUM_CLASSES, INT_SIZE and IDX_W defaults.
  - State enum: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - THRESHOLD default.
- Sub-module tm_sum_clamp: combinational signed saturator, INT_SIZE/THRESHOLD parameters. Instantiated once per class under TM_CLAMP_EN.

Test Plan:
- Basic argmax: sums {3,-7,12,0,5,-1,4,9,2,11}, raise full_done → pred_valid after 9 cycles, pred_class=2, pred_sum=12; pred_ready=1 → IDLE next cycle.
- Tie and all-negative: sums all -5 except classes 4 and 7 = -2 → pred_class=4, pred_sum=-2.
- Backpressure: pred_ready held 0 for 20 cycles → pred_valid and outputs stable; full_done toggled low-high meanwhile → no second result; ready=1 → single transfer.
- Reset mid-SCAN: assert rst_flag at scan cycle 4 → next edge pred_valid=0, busy=0, state IDLE; full_done held high after reset → new capture and a correct result.
- Clamp (TM_CLAMP_EN, T=15): sums class1=40, class6=20, others 0 → pred_class=1, pred_sum=15. Same stimulus without the macro → pred_class=1, pred_sum=40.
- Max at last index and extremes: class9=32'sh7FFFFFFF, class0=32'sh80000000 → pred_class=9, pred_sum=32'sh7FFFFFFF.
